seg7_bcd_scanner: RTL

//  Board-side seven-segment display driver that consumes a binary value and produces the 11-bit
//  {anode[3:0], segment[6:0]} bus on the FPGA display pins. Converts with a sequential

---
 rtl/seg7_bcd_scanner.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg7_bcd_scanner.sv
// Binary value to 4-digit multiplexed seven-segment display driver.
// Sequential double-dabble conversion feeds atomically updated digit registers.
module seg7_bcd_scanner #(
  parameter int VALUE_BIT      = 13,
  parameter int REFRESH_CYCLES = 50000,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [VALUE_BIT-1:0] value_in,
  input  logic                 value_valid,
  input  logic                 blank,
  output logic                 busy,
  output logic [10:0]          display_out
);

  localparam int CW = $clog2(VALUE_BIT + 1);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(VALUE_BIT - 1);
  localparam logic [RW-1:0] LAST_REF = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [VALUE_BIT-1:0] bin_sr;
  logic [15:0]          bcd_sr;
  logic [15:0]          bcd_adj;
  logic [15:0]          digits;
  logic [CW-1:0]        bit_cnt;
  logic [RW-1:0]        ref_cnt;
  logic [1:0]           sel;
  logic [3:0]           cur_digit;
  logic [3:0]           anode;
  logic [6:0]           pat;
  logic [6:0]           seg;
  logic                 cur_blank;
  logic                 lz3;
  logic                 lz2;
  logic                 lz1;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: IDLE -> SHIFT -> LATCH -> IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (value_valid) state_nx = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction on every BCD nibble that would overflow when doubled
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion datapath and atomic digit update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      digits  <= '0;
    end else begin
      if (state == IDLE && value_valid) begin
        bin_sr  <= value_in;
        bcd_sr  <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        {bcd_sr, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
        bit_cnt          <= bit_cnt + 1'b1;
      end else if (state == LATCH) begin
        digits <= bcd_sr;
      end
    end
  end

  // Free-running refresh counter and digit select
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_cnt <= '0;
      sel     <= '0;
    end else if (ref_cnt == LAST_REF) begin
      ref_cnt <= '0;
      sel     <= sel + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign lz3 = (digits[15:12] == 4'd0);
  assign lz2 = lz3 && (digits[11:8] == 4'd0);
  assign lz1 = lz2 && (digits[7:4] == 4'd0);

  // Select the lit digit, its anode and its leading-zero blank
  always_comb begin
    anode     = 4'b1111;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    unique case (sel)
      2'd0: begin
        anode     = 4'b0111;
        cur_digit = digits[15:12];
        cur_blank = LZ_BLANK && lz3;
      end
      2'd1: begin
        anode     = 4'b1011;
        cur_digit = digits[11:8];
        cur_blank = LZ_BLANK && lz2;
      end
      2'd2: begin
        anode     = 4'b1101;
        cur_digit = digits[7:4];
        cur_blank = LZ_BLANK && lz1;
      end
      2'd3: begin
        anode     = 4'b1110;
        cur_digit = digits[3:0];
      end
      default: anode = 4'b1111;
    endcase
  end

  // Active-high a..g pattern per BCD digit
  always_comb begin
    pat = 7'b0000000;
    unique case (cur_digit)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = 7'b0000000;
    endcase
  end

  assign seg = cur_blank ? 7'h7F : ~pat;

  // Registered pin drive; blank overrides everything
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        display_out <= 11'h7FF;
    else if (blank) display_out <= 11'h7FF;
    else            display_out <= {anode, seg};
  end

endmodule
